encoder4to2_pending: RTL

//  Sequential 4-to-2 encoder: reverse direction of the 2-to-4 line decoder.

---
 rtl/enc_pkg.sv | 27 ++
 rtl/prio_pick4.sv | 50 +++++
 rtl/encoder4to2_pending.sv | 85 ++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared sizing constants and index/one-hot helpers for the 4-to-2 pending encoder.
package enc_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Binary index of a one-hot vector; an all-zero input yields index 0.
  function automatic idx_t onehot_to_idx(input req_t oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // One-hot vector with only the bit at idx set.
  function automatic req_t idx_to_onehot(input idx_t idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational picker: chooses one set bit of cand, either the highest index
// (fixed priority) or the first set bit found scanning upward from start with
// wrap-around (round robin).
module prio_pick4
  import enc_pkg::*;
(
  input  logic [3:0] cand,
  input  logic [1:0] start,
  input  logic       rr_en,
  output logic [1:0] idx,
  output logic       any
);

  req_t rot;          // cand rotated so that rot[0] is cand[start]
  idx_t src_idx [N_REQ];
  req_t fp_oh;
  req_t rr_oh;
  idx_t rr_idx;

  // Rotate the candidate vector so the round-robin scan becomes a lowest-bit search.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign src_idx[gi] = start + IDX_W'(gi);
    assign rot[gi]     = cand[src_idx[gi]];
  end

  // Fixed priority: the last matching assignment in an upward scan is the highest index.
  always_comb begin
    fp_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i]) begin
        fp_oh = idx_to_onehot(IDX_W'(i));
      end
    end
  end

  // Round robin: lowest set bit of the rotated vector, mapped back by adding start.
  always_comb begin
    rr_oh = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rr_oh = idx_to_onehot(IDX_W'(i));
      end
    end
    rr_idx = start + onehot_to_idx(rr_oh);
  end

  assign idx = rr_en ? rr_idx : onehot_to_idx(fp_oh);
  assign any = |cand;

endmodule

// File: rtl/encoder4to2_pending.sv
// Sequential 4-to-2 encoder: collects request pulses into a pending register and
// hands out one binary index at a time over a valid/ready handshake.
module encoder4to2_pending
  import enc_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       drop,
  output logic       busy
);

  req_t pending_q, pending_d;
  idx_t code_q, code_d;
  logic code_valid_q, code_valid_d;
  idx_t last_q, last_d;
  logic drop_q, drop_d;

  logic rr_en;
  logic slot_free;
  logic load;
  req_t cand;
  req_t grant_oh;
  idx_t rr_start;
  idx_t pick_idx;
  logic pick_any;

  assign rr_en    = (ROUND_ROBIN != 0);
  // A new request competes in the same edge it is sampled.
  assign cand     = pending_q | req;
  assign rr_start = last_q + 2'd1;
  // The output register can take a new index when empty or being consumed now.
  assign slot_free = ~code_valid_q | code_ready;

  prio_pick4 u_pick (
    .cand  (cand),
    .start (rr_start),
    .rr_en (rr_en),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state logic for the pending set, output slot, round-robin pointer and drop pulse.
  always_comb begin
    load     = slot_free & pick_any;
    grant_oh = load ? idx_to_onehot(pick_idx) : '0;
    // The granted bit leaves the pending set, except when it was already pending
    // and re-requested this cycle: the fresh request survives for a later grant.
    // A granted bit that came straight from req is consumed outright.
    pending_d    = (cand & ~grant_oh) | (grant_oh & pending_q & req);
    // A request hitting a bit that stays pending is merged and therefore lost.
    drop_d       = |(req & pending_q & ~grant_oh);
    code_d       = load ? pick_idx : code_q;
    code_valid_d = slot_free ? pick_any : code_valid_q;
    last_d       = load ? pick_idx : last_q;
  end

  // State registers; reset clears everything and aims the first RR search at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      last_q       <= 2'd3;
      drop_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      last_q       <= last_d;
      drop_q       <= drop_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign drop       = drop_q;
  assign busy       = (|pending_q) | code_valid_q;

endmodule
